// File: rtl/timed_counter_fsm.sv
// Purpose : prescaled up/down counter sequenced by an IDLE/COUNTING/PAUSED/DONE FSM.
// Latency : state and count update one clk after the deciding input; count steps once per DIV_COUNT clk.
// Backpressure: none; pause holds the count and prescaler, stop aborts to IDLE.
//
// Ports: clk, rst (async, active-high); go/stop/pause control; down/limit captured at start;
//        count (registered), busy (COUNTING|PAUSED), done (DONE), state (IDLE=0..DONE=3).
// Build option: define COUNTER_AUTO_RELOAD_EN to make DONE restart the count with the
//        previously captured limit/direction instead of returning to IDLE.
module timed_counter_fsm #(
    parameter int WIDTH     = 4,
    parameter int DIV_COUNT = 1500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             stop,
    input  logic             pause,
    input  logic             down,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        PAUSED   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dn_q, dn_d;
    logic [PW-1:0]    pre_q, pre_d;

    logic             tick;
    logic [PW-1:0]    pre_inc;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] cnt_step;

    // The tick is the last prescaler cycle; the prescaler wraps on the same edge.
    assign tick     = (pre_q == PRE_LAST);
    assign pre_inc  = tick ? '0 : pre_q + 1'b1;
    assign terminal = dn_q ? '0 : lim_q;
    assign cnt_step = dn_q ? cnt_q - 1'b1 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            lim_q <= '0;
            dn_q  <= 1'b0;
            pre_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            lim_q <= lim_d;
            dn_q  <= dn_d;
            pre_q <= pre_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        lim_d = lim_q;
        dn_d  = dn_q;
        pre_d = pre_q;

        // stop outranks everything once the counter has left IDLE.
        if (st_q != IDLE && stop) begin
            st_d  = IDLE;
            cnt_d = '0;
            pre_d = '0;
        end else begin
            case (st_q)
                IDLE: begin
                    cnt_d = '0;
                    pre_d = '0;
                    if (go && !stop) begin
                        st_d  = COUNTING;
                        lim_d = limit;
                        dn_d  = down;
                        cnt_d = down ? limit : '0;
                    end
                end
                COUNTING: begin
                    // pause wins over a coincident tick: nothing advances on this edge.
                    if (pause) begin
                        st_d = PAUSED;
                    end else begin
                        pre_d = pre_inc;
                        if (tick) begin
                            if (cnt_q == terminal) begin
                                st_d = DONE;
                            end else begin
                                cnt_d = cnt_step;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        st_d = COUNTING;
                    end
                end
                DONE: begin
                    // DONE spans one full prescaler period, entered with the prescaler at 0.
                    pre_d = pre_inc;
                    if (tick) begin
`ifdef COUNTER_AUTO_RELOAD_EN
                        st_d  = COUNTING;
                        cnt_d = dn_q ? lim_q : '0;
`else
                        st_d  = IDLE;
                        cnt_d = '0;
`endif
                    end
                end
                default: begin
                    // Any corrupted encoding falls back to a clean IDLE.
                    st_d  = IDLE;
                    cnt_d = '0;
                    pre_d = '0;
                end
            endcase
        end
    end

    assign count = cnt_q;
    assign state = st_q;
    assign busy  = (st_q == COUNTING) || (st_q == PAUSED);
    assign done  = (st_q == DONE);

endmodule
